sha256_arbiter: RTL and testbench
=================================

SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of WAIT-state cycles before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports req0_data / req1_data, input, 32, the message word from requester 0 / 1.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1, the requester word-valid signal.
REQ-006 SHALL have ports req0_last / req1_last, input, 1, marking the final word of a message.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1, the word accepted when valid&&ready.
REQ-008 SHALL have ports core_data (output, 32), core_valid (output, 1) and core_last (output, 1), driving the sha256 core's input_data, input_valid and last_word.
REQ-009 SHALL have port core_ready, input, 1, from the core's input_ready.
REQ-010 SHALL have ports core_out_valid (input, 1) and core_hash (input, 256), from the core's output_valid and hash_data.
REQ-011 SHALL have ports hash_out (output, 256), hash_valid (output, 1) and hash_id (output, 1), delivering the result and the owning requester.
REQ-012 SHALL have ports busy (output, 1), high outside IDLE, and err (output, 1), a timeout pulse.

Function
REQ-013 SHALL implement the states IDLE, FEED and WAIT.
REQ-014 In IDLE, if any reqN_valid is high, SHALL register grant and enter FEED next cycle; no word is transferred in the IDLE cycle.
REQ-015 When both requesters are valid in IDLE, SHALL grant the requester not served last (round-robin); after reset, requester 0 wins the first tie.
REQ-016 When exactly one requester is valid, SHALL grant it regardless of the round-robin pointer.
REQ-017 In FEED, SHALL combinationally pass through: core_data = granted data, core_valid = granted valid, core_last = granted valid & granted last, granted ready = core_ready.
REQ-018 SHALL hold the non-granted ready at 0 in every state, and all reqN_ready at 0 in IDLE and WAIT.
REQ-019 SHALL drive core_valid and core_last at 0 outside FEED.
REQ-020 SHALL hold the grant for the whole message; a transfer with last=1 moves FEED to WAIT and updates the round-robin pointer.
REQ-021 In WAIT, when core_out_valid=1, SHALL register hash_out <= core_hash, hash_id <= grant and hash_valid <= 1 for exactly one cycle, then return to IDLE.
REQ-022 core_out_valid in IDLE or FEED SHALL be ignored.
REQ-023 SHALL allow the next arbitration in the IDLE cycle that follows the hash_valid cycle, giving at least one idle cycle between messages.
REQ-024 hash_out SHALL hold its value until the next capture.

Reset
REQ-025 On rst=1, immediately and independently of clk, SHALL force state IDLE, round-robin pointer to requester 0, hash_out=0, hash_valid=0, hash_id=0, err=0, busy=0, and the timeout counter to 0.
REQ-026 Reset asserted mid-FEED or mid-WAIT SHALL abandon the message with no hash_valid and no err.

Configuration
REQ-027 With SHA256_ARB_TIMEOUT_EN defined, SHALL count cycles in WAIT from 0; if the count reaches TIMEOUT_CYCLES-1 without core_out_valid, SHALL pulse err for one cycle with hash_id = grant, leave hash_valid at 0, and return to IDLE.
REQ-028 If core_out_valid and the timeout occur in the same cycle, the hash SHALL win: hash_valid=1 and err=0.
REQ-029 Without SHA256_ARB_TIMEOUT_EN, WAIT SHALL persist until core_out_valid, err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-030 Single message: req0 sends 3 words 0x61626380, 0x0, 0x18 (last) with core_ready=1, and the core model returns hash H after 64 cycles -> one hash_valid pulse, hash_out=H, hash_id=0.
REQ-031 Tie: req0 and req1 both valid in IDLE after reset -> req0 is served first, then req1 is granted with no words interleaved; hash_id sequence is 0,1.
REQ-032 Backpressure: core_ready toggles every cycle during a 24-word req1 message -> exactly 24 transfers, req1_ready mirrors core_ready, and req0_ready stays 0.
REQ-033 Reset mid-FEED after word 5 -> all outputs are 0 at once, the next message is granted from IDLE, and no stale hash_valid appears.
REQ-034 With SHA256_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the core never asserts core_out_valid -> err pulses once, hash_valid stays 0, and the block is back in IDLE.
REQ-035 Spurious core_out_valid in IDLE -> hash_valid stays 0 and hash_out is unchanged.

Source files
------------

// File: rtl/sha256_arbiter.sv
// Two-requester round-robin front end for a sha256 core: one message at a time, hash returned with owner id.
// Optional WAIT-state timeout is compiled in when SHA256_ARB_TIMEOUT_EN is defined.
module sha256_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  req0_data,
  input  logic         req0_valid,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic [31:0]  req1_data,
  input  logic         req1_valid,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic [31:0]  core_data,
  output logic         core_valid,
  output logic         core_last,
  input  logic         core_ready,
  input  logic         core_out_valid,
  input  logic [255:0] core_hash,
  output logic [255:0] hash_out,
  output logic         hash_valid,
  output logic         hash_id,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         grant_q, grant_d;
  logic         rr_q, rr_d;
  logic [255:0] hash_out_q, hash_out_d;
  logic         hash_valid_q, hash_valid_d;
  logic         hash_id_q, hash_id_d;
  logic         pick_s;
  logic [31:0]  g_data_s;
  logic         g_valid_s;
  logic         g_last_s;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sha256_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef SHA256_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign g_data_s  = grant_q ? req1_data  : req0_data;
  assign g_valid_s = grant_q ? req1_valid : req0_valid;
  assign g_last_s  = grant_q ? req1_last  : req0_last;

  // Tie goes to the requester rr_q points at; a lone requester always wins.
  always_comb begin
    pick_s = 1'b0;
    if (req0_valid && req1_valid) begin
      pick_s = rr_q;
    end else if (req1_valid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Next-state logic plus the combinational core-side pass-through.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    hash_out_d   = hash_out_q;
    hash_valid_d = 1'b0;
    hash_id_d    = hash_id_q;
    core_data    = 32'd0;
    core_valid   = 1'b0;
    core_last    = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
`ifdef SHA256_ARB_TIMEOUT_EN
    cnt_d        = '0;
    err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Hold off while the previous result is still being presented.
        if ((req0_valid || req1_valid) && !hash_valid_q && !err) begin
          grant_d = pick_s;
          state_d = S_FEED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        core_data  = g_data_s;
        core_valid = g_valid_s;
        core_last  = g_valid_s & g_last_s;
        if (grant_q) begin
          req1_ready = core_ready;
        end else begin
          req0_ready = core_ready;
        end
        if (g_valid_s && g_last_s && core_ready) begin
          state_d = S_WAIT;
          rr_d    = ~grant_q;
        end else begin
          state_d = S_FEED;
        end
      end
      S_WAIT: begin
        if (core_out_valid) begin
          hash_out_d   = core_hash;
          hash_id_d    = grant_q;
          hash_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
`ifdef SHA256_ARB_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            err_d     = 1'b1;
            hash_id_d = grant_q;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      rr_q         <= 1'b0;
      hash_out_q   <= 256'd0;
      hash_valid_q <= 1'b0;
      hash_id_q    <= 1'b0;
`ifdef SHA256_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      hash_out_q   <= hash_out_d;
      hash_valid_q <= hash_valid_d;
      hash_id_q    <= hash_id_d;
`ifdef SHA256_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign hash_out   = hash_out_q;
  assign hash_valid = hash_valid_q;
  assign hash_id    = hash_id_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_arbiter.sv
// Scoreboard bench for sha256_arbiter: random requesters, a behavioural core model and queue-based checking.
module tb_sha256_arbiter;
  localparam int TO = 16;
  localparam logic [31:0] H0 = 32'h6A09E667;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [31:0] req0_data, req1_data;
  logic req0_valid, req1_valid, req0_last, req1_last;
  logic req0_ready, req1_ready;
  logic [31:0] core_data;
  logic core_valid, core_last, core_ready;
  logic cov_m, spur_v;
  logic [255:0] hash_m, spur_h;
  logic [255:0] hash_out;
  logic hash_valid, hash_id, busy, err;

  sha256_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .core_data(core_data), .core_valid(core_valid), .core_last(core_last), .core_ready(core_ready),
    .core_out_valid(cov_m | spur_v), .core_hash(spur_v ? spur_h : hash_m),
    .hash_out(hash_out), .hash_valid(hash_valid), .hash_id(hash_id), .busy(busy), .err(err)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic [32:0]  exp_w0[$], exp_w1[$];
  logic [255:0] exp_h0[$], exp_h1[$];
  int own_seq[$], hid_seq[$];
  bit in_msg = 1'b0;
  int owner = 0;
  int xfer0 = 0, xfer1 = 0, hv_cnt = 0, err_cnt = 0;
  bit abort_v = 1'b0, chk_r0_zero = 1'b0, use_fixed = 1'b0, core_silent = 1'b0, lat_rand = 1'b0;
  int core_mode = 0, core_lat = 4;
  logic [255:0] last_hash = 256'd0;
  logic [31:0] fixed_w[3] = '{32'h61626380, 32'h00000000, 32'h00000018};

  function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] w);
    return ({a[26:0], a[31:27]} ^ w) + 32'h9E3779B9;
  endfunction

  function automatic logic [255:0] hfun(input logic [31:0] a, input int n);
    return {a, ~a, a ^ 32'(n), 32'(n), a + 32'd1, {a[15:0], a[31:16]}, a ^ 32'hA5A5A5A5, a * 32'd3};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int id, input logic v, input logic [31:0] d, input logic l);
    if (id == 0) begin
      req0_valid = v; req0_data = d; req0_last = l;
    end else begin
      req1_valid = v; req1_data = d; req1_last = l;
    end
  endtask

  task automatic send(input int id, input int len, input bit gaps);
    logic [31:0] w, acc;
    logic last;
    int t;
    acc = H0;
    for (int i = 0; i < len; i++) begin
      if (abort_v) break;
      w = use_fixed ? fixed_w[i] : $urandom;
      last = (i == len - 1);
      acc = mix(acc, w);
      if (id == 0) exp_w0.push_back({last, w}); else exp_w1.push_back({last, w});
      if (last) begin
        if (id == 0) exp_h0.push_back(hfun(acc, len)); else exp_h1.push_back(hfun(acc, len));
      end
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          drv(id, 1'b0, 32'd0, 1'b0);
          @(posedge clk); #1;
        end
      end
      drv(id, 1'b1, w, last);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(id == 1 ? req1_ready : req0_ready) && !abort_v && t < 5000);
      chk("send_handshake_bound", t < 5000, 1);
      @(posedge clk); #1;
    end
    drv(id, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while ((exp_h0.size() != 0 || exp_h1.size() != 0 || busy || hash_valid) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk(nm, t < 20000, 1);
  endtask

  task automatic flush();
    exp_w0.delete(); exp_w1.delete(); exp_h0.delete(); exp_h1.delete();
    in_msg = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hash_out"}, hash_out, 256'd0);
    chk({tag, "_flags"}, {hash_valid, hash_id, err, busy, core_valid, core_last, req0_ready, req1_ready}, 8'h00);
  endtask

  // Core model: absorbs words, returns a digest of them after a latency.
  initial begin
    logic [31:0] cacc;
    logic [255:0] ph;
    int cn, cd;
    cov_m = 1'b0; hash_m = 256'd0; core_ready = 1'b1;
    cacc = H0; cn = 0; cd = 0; ph = 256'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cacc = H0; cn = 0; cd = 0;
      end else if (core_valid && core_ready) begin
        cacc = mix(cacc, core_data);
        cn++;
        if (core_last) begin
          ph = hfun(cacc, cn);
          cacc = H0; cn = 0;
          cd = lat_rand ? $urandom_range(1, 10) : core_lat;
        end
      end
      @(posedge clk); #1;
      cov_m = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !core_silent && !rst) begin
          cov_m = 1'b1;
          hash_m = ph;
        end
      end
      case (core_mode)
        0: core_ready = 1'b1;
        1: core_ready = ~core_ready;
        default: core_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks every transfer and every result against the expectation queues.
  initial begin
    logic [32:0] e;
    logic [255:0] eh;
    int id;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ready_exclusive", req0_ready & req1_ready, 1'b0);
        if (core_valid) chk("ready_mirrors_core", req0_ready | req1_ready, core_ready);
        if (chk_r0_zero) chk("req0_ready_idle", req0_ready, 1'b0);
        if (core_valid && core_ready) begin
          id = req1_ready ? 1 : 0;
          if (id == 0) begin
            chk("xfer_expected", exp_w0.size() != 0, 1);
            e = (exp_w0.size() != 0) ? exp_w0.pop_front() : 33'd0;
          end else begin
            chk("xfer_expected", exp_w1.size() != 0, 1);
            e = (exp_w1.size() != 0) ? exp_w1.pop_front() : 33'd0;
          end
          chk("xfer_data", core_data, e[31:0]);
          chk("xfer_last", core_last, e[32]);
          if (!in_msg) begin
            own_seq.push_back(id);
            owner = id;
          end else begin
            chk("owner_held", id, owner);
          end
          in_msg = !core_last;
          if (id == 0) xfer0++; else xfer1++;
        end
        if (hash_valid) begin
          hv_cnt++;
          hid_seq.push_back(int'(hash_id));
          if (hash_id) begin
            chk("hash_expected", exp_h1.size() != 0, 1);
            eh = (exp_h1.size() != 0) ? exp_h1.pop_front() : 256'd0;
          end else begin
            chk("hash_expected", exp_h0.size() != 0, 1);
            eh = (exp_h0.size() != 0) ? exp_h0.pop_front() : 256'd0;
          end
          chk("hash_out", hash_out, eh);
          last_hash = eh;
        end
        if (err) err_cnt++;
      end
    end
  end

  initial begin
    logic [255:0] rec;
    int x0, hv0, t;
    rst = 1'b1; spur_v = 1'b0; spur_h = 256'd0;
    drv(0, 1'b0, 32'd0, 1'b0);
    drv(1, 1'b0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Single known message from requester 0.
`ifdef SHA256_ARB_TIMEOUT_EN
    core_lat = 10;
`else
    core_lat = 64;
`endif
    use_fixed = 1'b1;
    send(0, 3, 1'b0);
    use_fixed = 1'b0;
    wait_done("single_done");
    chk("single_hv_count", hv_cnt, 1);
    chk("single_hash_id", hash_id, 1'b0);
    repeat (5) @(negedge clk);
    chk("hash_hold", hash_out, last_hash);

    // Spurious core_out_valid while idle.
    rec = hash_out; hv0 = hv_cnt;
    @(posedge clk); #1;
    spur_v = 1'b1; spur_h = {8{$urandom}};
    @(posedge clk); #1;
    spur_v = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_no_hv", hv_cnt, hv0);
    chk("spur_hash_kept", hash_out, rec);

    // Tie right after reset.
    do_reset();
    own_seq.delete(); hid_seq.delete();
    core_lat = 5;
    fork
      send(0, 4, 1'b1);
      send(1, 5, 1'b1);
    join
    wait_done("tie_done");
    chk("tie_msgs", own_seq.size(), 2);
    chk("tie_first", own_seq[0], 0);
    chk("tie_second", own_seq[1], 1);
    chk("tie_hid_count", hid_seq.size(), 2);
    chk("tie_hid_order", {hid_seq[0] == 0, hid_seq[1] == 1}, 2'b11);

    // Backpressure on a 24-word requester 1 message.
    core_mode = 1; chk_r0_zero = 1'b1;
    x0 = xfer1;
    send(1, 24, 1'b0);
    wait_done("bp_done");
    chk("bp_xfers", xfer1 - x0, 24);
    chk_r0_zero = 1'b0; core_mode = 0;

    // Reset in the middle of a message.
    hv0 = hv_cnt; x0 = xfer0;
    fork
      send(0, 10, 1'b0);
      begin
        t = 0;
        while (xfer0 < x0 + 5 && t < 1000) begin
          @(negedge clk);
          t++;
        end
        chk("midfeed_bound", t < 1000, 1);
        @(posedge clk); #2;
        abort_v = 1'b1;
        rst = 1'b1;
        #1;
        check_zero("midfeed_reset");
      end
    join
    repeat (2) @(posedge clk);
    #1;
    flush();
    abort_v = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midfeed_no_stale", hv_cnt, hv0);
    hid_seq.delete();
    send(1, 3, 1'b1);
    wait_done("post_reset_done");
    chk("post_reset_hv", hv_cnt, hv0 + 1);
    chk("post_reset_id", hid_seq.size() == 1 && hid_seq[0] == 1, 1'b1);

`ifdef SHA256_ARB_TIMEOUT_EN
    // Core never answers: timeout must fire once.
    core_silent = 1'b1;
    hv0 = hv_cnt; x0 = err_cnt;
    send(0, 2, 1'b0);
    exp_h0.delete();
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("timeout_bound", t < 200, 1);
    chk("timeout_err_once", err_cnt - x0, 1);
    chk("timeout_no_hv", hv_cnt, hv0);
    chk("timeout_idle", busy, 1'b0);
    core_silent = 1'b0;
`endif

    // Randomized contention: both requesters always pending, service must alternate.
    do_reset();
    own_seq.delete();
    core_mode = 2; lat_rand = 1'b1;
    fork
      for (int k = 0; k < 6; k++) send(0, $urandom_range(1, 8), 1'b1);
      for (int k = 0; k < 6; k++) send(1, $urandom_range(1, 8), 1'b1);
    join
    wait_done("rand_done");
    chk("rand_msgs", own_seq.size(), 12);
    for (int k = 0; k < own_seq.size(); k++) chk("rand_alternate", own_seq[k], k % 2);
    chk("queues_empty", exp_w0.size() + exp_w1.size() + exp_h0.size() + exp_h1.size(), 0);
`ifndef SHA256_ARB_TIMEOUT_EN
    chk("err_never", err_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
